// File: rtl/fpu_pipe_pkg.sv
// Shared sizing constants for the FP pipeline register file and its pipeline buffers.
package fpu_pipe_pkg;

    localparam int unsigned DSIZE_DEF = 32;
    localparam int unsigned ASIZE_DEF = 5;
    localparam int unsigned NREGS_DEF = 1 << ASIZE_DEF;

    // Number of architectural registers addressed by an asize-bit index.
    function automatic int unsigned nregs(input int unsigned asize);
        return 1 << asize;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Pending-write scoreboard: tracks in-flight producers and blocks issue on RAW/WAW hazards.
module fp_scoreboard
    import fpu_pipe_pkg::*;
#(
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [ASIZE-1:0]         wb_addr,
    input  logic [ASIZE-1:0]         rs1_addr,
    input  logic [ASIZE-1:0]         rs2_addr,
    input  logic                     issue_valid,
    input  logic [ASIZE-1:0]         issue_rd,
    output logic                     stall,
    output logic [(1<<ASIZE)-1:0]    busy
);

    localparam int unsigned NREGS = nregs(ASIZE);

    logic             rs1_haz;
    logic             rs2_haz;
    logic             waw_haz;
    logic             accept;
    logic [NREGS-1:0] busy_nxt;

    // Hazard detection; a write-back landing this edge resolves its own register.
    always_comb begin
        rs1_haz  = 1'b0;
        rs2_haz  = 1'b0;
        waw_haz  = 1'b0;
        stall    = 1'b0;
        accept   = 1'b0;
        busy_nxt = busy;

        rs1_haz = busy[rs1_addr] && !(wb_valid && (wb_addr == rs1_addr));
        rs2_haz = busy[rs2_addr] && !(wb_valid && (wb_addr == rs2_addr));
        waw_haz = busy[issue_rd] && !(wb_valid && (wb_addr == issue_rd));
        stall   = issue_valid && (rs1_haz || rs2_haz || waw_haz);
        accept  = issue_valid && !stall;

        // Clear before set so a new producer on the same register stays pending.
        if (wb_valid) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (accept) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    // Busy vector register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/fp_wb_regfile.sv
// FP register file with write-back bypass on registered reads and an issue scoreboard.
module fp_wb_regfile
    import fpu_pipe_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [ASIZE-1:0]         wb_addr,
    input  logic [DSIZE-1:0]         wb_data,
    input  logic [ASIZE-1:0]         rs1_addr,
    input  logic [ASIZE-1:0]         rs2_addr,
    output logic [DSIZE-1:0]         rs1_data,
    output logic [DSIZE-1:0]         rs2_data,
    input  logic                     issue_valid,
    input  logic [ASIZE-1:0]         issue_rd,
    output logic                     stall,
    output logic [(1<<ASIZE)-1:0]    busy
);

    localparam int unsigned NREGS = nregs(ASIZE);

    logic [DSIZE-1:0] regs [NREGS];
    logic [DSIZE-1:0] rs1_byp;
    logic [DSIZE-1:0] rs2_byp;

    fp_scoreboard #(
        .ASIZE (ASIZE)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .stall       (stall),
        .busy        (busy)
    );

    // Forward the write-back value when it targets a register being read this edge.
    always_comb begin
        rs1_byp = regs[rs1_addr];
        rs2_byp = regs[rs2_addr];
        if (wb_valid && (wb_addr == rs1_addr)) begin
            rs1_byp = wb_data;
        end
        if (wb_valid && (wb_addr == rs2_addr)) begin
            rs2_byp = wb_data;
        end
    end

    // Storage write and registered operand reads; reset drops any in-flight write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs     <= '{default: '0};
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            if (wb_valid) begin
                regs[wb_addr] <= wb_data;
            end
            rs1_data <= rs1_byp;
            rs2_data <= rs2_byp;
        end
    end

endmodule

// File: doc/fp_wb_regfile.md
FP_WB_REGFILE -- requirements
Module: fp_wb_regfile

Interface
REQ-001 Parameter DSIZE, default 32, sets the data word width.
REQ-002 Parameter ASIZE, default 5, sets the register address width; the file holds 2**ASIZE entries.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wb_valid  input  1  write-back request from the EX/WB buffer.
REQ-006 wb_addr  input  ASIZE  destination register of the write-back.
REQ-007 wb_data  input  DSIZE  result to write.
REQ-008 rs1_addr, rs2_addr  input  ASIZE each  source register addresses from decode.
REQ-009 rs1_data, rs2_data  output  DSIZE each  registered source operands.
REQ-010 issue_valid  input  1  decode requests issue of an instruction.
REQ-011 issue_rd  input  ASIZE  destination register of the issuing instruction.
REQ-012 stall  output  1  combinational; issue blocked this cycle.
REQ-013 busy  output  2**ASIZE  scoreboard vector; bit n set = register n has a write pending.

Function
REQ-014 Write: on an edge with wb_valid=1, entry wb_addr SHALL take wb_data; all 2**ASIZE entries are writable, with no hardwired zero.
REQ-015 Read: rs1_data/rs2_data SHALL register the addressed entry on each edge, giving 1-cycle latency.
REQ-016 Bypass: if wb_valid=1 and wb_addr equals rsN_addr on the same edge, rsN_data SHALL capture wb_data, not the old entry.
REQ-017 Hazard (per source): a source has a hazard when busy[rsN_addr]=1 and NOT (wb_valid=1 and wb_addr=rsN_addr).
REQ-018 WAW term: busy[issue_rd]=1 and NOT (wb_valid=1 and wb_addr=issue_rd).
REQ-019 stall SHALL equal issue_valid AND (rs1 hazard OR rs2 hazard OR WAW term).
REQ-020 Accepted issue = issue_valid=1 and stall=0; it SHALL set busy[issue_rd] on the edge.
REQ-021 A write-back (wb_valid=1) SHALL clear busy[wb_addr] on the edge.
REQ-022 Set and clear of the same bit on the same edge: the set SHALL win, so the new producer stays pending.
REQ-023 A write-back to a non-busy register SHALL still write data; the busy bit stays 0.
REQ-024 Reads and bypass SHALL operate regardless of stall; decode discards stalled operands.
REQ-025 When issue_valid=0, stall SHALL be 0.

Reset
REQ-026 On an edge with rst=1, all entries, rs1_data, rs2_data and busy SHALL become 0.
REQ-027 rst SHALL override wb_valid and issue_valid on the same edge; pending write-backs in flight are lost.
REQ-028 stall SHALL be 0 in the cycle after reset, absent new issue hazards.

Structure
REQ-029 DSIZE/ASIZE defaults and the register-count constant SHALL live in a shared package fpu_pipe_pkg, also used by the pipeline buffers.
REQ-030 The scoreboard (REQ-017 to REQ-022) SHALL be a sub-module fp_scoreboard.
REQ-031 Storage and bypass SHALL stay in the top module.

Verification
REQ-032 Reset, then wb r3=0x3F800000, read rs1=3 next cycle -> rs1_data=0x3F800000 one edge later.
REQ-033 Same edge: wb r7=0x40490FDB with rs2_addr=7 -> rs2_data=0x40490FDB after that edge (bypass).
REQ-034 Issue rd=5 (accepted), next cycle issue with rs1=5 -> stall=1; wb r5 arrives that cycle -> stall=0 and the issue is accepted.
REQ-035 Same edge: wb r9 and accepted issue rd=9 -> busy[9]=1 after the edge.
REQ-036 Busy r2, then issue_valid with issue_rd=2 and no wb -> stall=1, busy unchanged.
REQ-037 Reset asserted with wb_valid=1 to r4=0x12345678 -> r4 reads 0, busy=0.
